// File: rtl/serial_link_pkg.sv
// rtl/serial_link_pkg.sv - shared constants and state type for the MBED serial link
package serial_link_pkg;

  localparam int INSTR_WIDTH          = 10;
  localparam int DEF_SYNC_STAGES      = 2;
  localparam int DEF_SETUP_CYCLES     = 2;
  localparam int DEF_TIMEOUT_CYCLES   = 5000;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_RDY = 3'd1,
    SETUP    = 3'd2,
    CONFIRM  = 3'd3,
    DONE     = 3'd4
  } tx_state_e;

endpackage

// File: rtl/bit_synchronizer.sv
// rtl/bit_synchronizer.sv - multi-flop synchroniser for a single asynchronous level
module bit_synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_ff;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_ff <= '0;
    end else begin
      sync_ff <= {sync_ff[STAGES-2:0], d};
    end
  end

  assign q = sync_ff[STAGES-1];

endmodule

// File: rtl/status_serializer.sv
// rtl/status_serializer.sv - FPGA-to-MBED status word transmitter, MSB first, 4-phase handshake
module status_serializer
  import serial_link_pkg::*;
#(
  parameter int WIDTH          = INSTR_WIDTH,
  parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int SETUP_CYCLES   = DEF_SETUP_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_word,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             timeout_err,
  input  logic             host_ready,
  output logic             tx_bit,
  output logic             tx_confirm
);

  localparam int CNT_MAX = (TIMEOUT_CYCLES > SETUP_CYCLES) ? TIMEOUT_CYCLES : SETUP_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int BW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam bit TO_EN   = (TIMEOUT_CYCLES > 0);

  localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST   = TO_EN ? CW'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [BW-1:0] BIT_LAST   = BW'(WIDTH - 1);

  tx_state_e        state, state_d;
  logic [WIDTH-1:0] shreg;
  logic [BW-1:0]    bit_cnt;
  logic [CW-1:0]    cnt;
  logic             rdy_s;
  logic             tmo_hit;
  logic             load_take;
  logic             shift_en;
  logic             tmo_fire;

  bit_synchronizer #(
    .STAGES (SYNC_STAGES)
  ) u_rdy_sync (
    .clk   (clk),
    .reset (reset),
    .d     (host_ready),
    .q     (rdy_s)
  );

  // cnt doubles as the setup timer and the per-phase stall timer; it restarts on every state change.
  assign tmo_hit = TO_EN && (cnt == TMO_LAST);

  always_comb begin
    state_d   = state;
    load_take = 1'b0;
    shift_en  = 1'b0;
    tmo_fire  = 1'b0;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            load_take = 1'b1;
            state_d   = WAIT_RDY;
          end
        end
        WAIT_RDY: begin
          if (rdy_s) begin
            state_d = SETUP;
          end else if (tmo_hit) begin
            tmo_fire = 1'b1;
            state_d  = IDLE;
          end
        end
        SETUP: begin
          // Host withdrew readiness during setup: never raise confirm against a low rdy_s.
          if (!rdy_s) begin
            state_d = WAIT_RDY;
          end else if (cnt == SETUP_LAST) begin
            state_d = CONFIRM;
          end
        end
        CONFIRM: begin
          if (!rdy_s) begin
            if (bit_cnt == BIT_LAST) begin
              state_d = DONE;
            end else begin
              shift_en = 1'b1;
              state_d  = WAIT_RDY;
            end
          end else if (tmo_hit) begin
            tmo_fire = 1'b1;
            state_d  = IDLE;
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      shreg       <= '0;
      bit_cnt     <= '0;
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_d;
      timeout_err <= tmo_fire;

      if (state_d != state || state == IDLE || state == DONE) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end

      if (load_take) begin
        shreg   <= load_word;
        bit_cnt <= '0;
      end else if (shift_en) begin
        shreg   <= shreg << 1;
        bit_cnt <= bit_cnt + BW'(1);
      end else if (state_d == IDLE) begin
        shreg   <= '0;
        bit_cnt <= '0;
      end
    end
  end

  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
  assign tx_confirm = (state == CONFIRM);
  assign tx_bit     = (state inside {WAIT_RDY, SETUP, CONFIRM}) ? shreg[WIDTH-1] : 1'b0;

endmodule

// File: tb/tb_status_serializer.sv
// tb/tb_status_serializer.sv - directed self-checking bench for status_serializer
module tb_status_serializer;

  localparam int W     = 10;
  localparam int SETUP = 2;
  localparam int TMO   = 50;

  logic         clk = 1'b0;
  logic         reset;
  logic         load;
  logic [W-1:0] load_word;
  logic         abort;
  logic         busy;
  logic         done;
  logic         timeout_err;
  logic         host_ready;
  logic         tx_bit;
  logic         tx_confirm;

  int passed = 0;
  int total  = 0;

  // host model state
  logic         model_en = 1'b0;
  logic         tb_ready = 1'b0;
  logic         clr_req  = 1'b0;
  logic         h_rdy    = 1'b1;
  logic         conf_q   = 1'b0;
  logic         bit_q    = 1'b0;
  logic [W-1:0] cap      = '0;
  int           stall_at = 0;
  int           n_conf   = 0;
  int           n_done   = 0;
  int           n_tmo    = 0;
  int           hcnt     = 0;
  int           stable   = 0;
  int           viol     = 0;
  int           cyc      = 0;
  int           t_rise   = 0;
  int           t_tmo    = 0;

  status_serializer #(
    .WIDTH          (W),
    .SYNC_STAGES    (2),
    .SETUP_CYCLES   (SETUP),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .load_word   (load_word),
    .abort       (abort),
    .busy        (busy),
    .done        (done),
    .timeout_err (timeout_err),
    .host_ready  (host_ready),
    .tx_bit      (tx_bit),
    .tx_confirm  (tx_confirm)
  );

  always #5 clk = ~clk;

  // MBED side: acks 3 cycles after a confirm rise, re-readies 4 cycles later; watches handshake rules.
  always @(negedge clk) begin
    cyc++;
    if (clr_req) begin
      n_conf = 0; n_done = 0; n_tmo = 0; cap = '0; hcnt = 0; h_rdy = 1'b1;
      t_rise = 0; t_tmo = 0;
    end else begin
      if (done) n_done++;
      if (timeout_err) begin n_tmo++; t_tmo = cyc; end
      if (tx_confirm && !conf_q) begin
        cap = {cap[W-2:0], tx_bit};
        n_conf++;
        t_rise = cyc;
        if (stable < SETUP) viol++;
        if (host_ready !== 1'b1) viol++;
        if (n_conf != stall_at) hcnt = 1;
      end else if (hcnt != 0) begin
        hcnt++;
        if (hcnt == 4) h_rdy = 1'b0;
        else if (hcnt == 8) begin h_rdy = 1'b1; hcnt = 0; end
      end
    end
    if (tx_confirm && conf_q && tx_bit !== bit_q) viol++;
    stable     = (tx_bit === bit_q) ? stable + 1 : 0;
    bit_q      = tx_bit;
    conf_q     = tx_confirm;
    host_ready = model_en ? h_rdy : tb_ready;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clr_model();
    clr_req = 1'b1;
    step();
    step();
    clr_req = 1'b0;
  endtask

  task automatic do_load(input logic [W-1:0] w);
    load      = 1'b1;
    load_word = w;
    step();
    load      = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (!done && k < 2000) begin step(); k++; end
    total++; if (done !== 1'b1) $display("FAIL %s_done_wait got=%0b exp=1 (no done within 2000 cycles)", tag, done); else passed++;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tb_ready  = ~tb_ready;
      load      = ~load;
      load_word = 10'h3FF;
      step();
      total++; if ({busy, done, timeout_err, tx_bit, tx_confirm} !== 5'b0) $display("FAIL reset_outputs got=%05b exp=00000", {busy, done, timeout_err, tx_bit, tx_confirm}); else passed++;
    end
    load  = 1'b0;
    reset = 1'b1;
    repeat (3) step();
    total++; if (busy !== 1'b0) $display("FAIL reset_release_busy got=%0b exp=0", busy); else passed++;
    total++; if ({done, timeout_err, tx_bit, tx_confirm} !== 4'b0) $display("FAIL reset_release_outputs got=%04b exp=0000", {done, timeout_err, tx_bit, tx_confirm}); else passed++;
    clr_model();
    model_en = 1'b1;
    step();
  endtask

  task automatic test_word();
    clr_model();
    do_load(10'b1011001110);
    total++; if (busy !== 1'b1) $display("FAIL word_latency_busy got=%0b exp=1", busy); else passed++;
    total++; if (tx_bit !== 1'b1) $display("FAIL word_latency_msb got=%0b exp=1", tx_bit); else passed++;
    total++; if (tx_confirm !== 1'b0) $display("FAIL word_first_confirm got=%0b exp=0", tx_confirm); else passed++;
    wait_done("word");
    total++; if (busy !== 1'b1) $display("FAIL word_busy_at_done got=%0b exp=1", busy); else passed++;
    step();
    total++; if (busy !== 1'b0) $display("FAIL word_busy_after_done got=%0b exp=0", busy); else passed++;
    total++; if (tx_bit !== 1'b0) $display("FAIL word_idle_tx_bit got=%0b exp=0", tx_bit); else passed++;
    total++; if (cap !== 10'b1011001110) $display("FAIL word_capture got=%b exp=1011001110", cap); else passed++;
    total++; if (n_conf !== 10) $display("FAIL word_confirm_count got=%0d exp=10", n_conf); else passed++;
    total++; if (n_done !== 1) $display("FAIL word_done_count got=%0d exp=1", n_done); else passed++;
  endtask

  task automatic test_ignore_load();
    int k;
    clr_model();
    do_load(10'h195);
    k = 0;
    while (n_conf < 3 && k < 1000) begin step(); k++; end
    total++; if (n_conf < 3) $display("FAIL ignore_wait_conf got=%0d exp=3", n_conf); else passed++;
    do_load(10'h3FF);
    wait_done("ignore");
    step();
    total++; if (cap !== 10'h195) $display("FAIL ignore_capture got=%h exp=195", cap); else passed++;
    total++; if (n_conf !== 10) $display("FAIL ignore_confirm_count got=%0d exp=10", n_conf); else passed++;
    repeat (40) step();
    total++; if (n_done !== 1) $display("FAIL ignore_done_count got=%0d exp=1", n_done); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL ignore_busy got=%0b exp=0", busy); else passed++;
  endtask

  task automatic test_timeout();
    int k;
    clr_model();
    stall_at = 3;
    do_load(10'h2D3);
    k = 0;
    while (!timeout_err && k < 1000) begin step(); k++; end
    total++; if (timeout_err !== 1'b1) $display("FAIL tmo_seen got=%0b exp=1", timeout_err); else passed++;
    total++; if (t_tmo - t_rise !== TMO) $display("FAIL tmo_delay got=%0d exp=%0d", t_tmo - t_rise, TMO); else passed++;
    total++; if ({busy, tx_confirm, tx_bit} !== 3'b000) $display("FAIL tmo_outputs got=%03b exp=000", {busy, tx_confirm, tx_bit}); else passed++;
    total++; if (n_conf !== 3) $display("FAIL tmo_confirm_count got=%0d exp=3", n_conf); else passed++;
    step();
    total++; if (timeout_err !== 1'b0) $display("FAIL tmo_pulse_width got=%0b exp=0", timeout_err); else passed++;
    repeat (10) step();
    total++; if (n_done !== 0) $display("FAIL tmo_no_done got=%0d exp=0", n_done); else passed++;
    total++; if (n_tmo !== 1) $display("FAIL tmo_count got=%0d exp=1", n_tmo); else passed++;
    stall_at = 0;
  endtask

  task automatic test_reset_mid();
    int k;
    clr_model();
    do_load(10'h3C3);
    k = 0;
    while (n_conf < 4 && k < 1000) begin step(); k++; end
    total++; if (n_conf < 4) $display("FAIL rmid_wait_conf got=%0d exp=4", n_conf); else passed++;
    step();
    #2 reset = 1'b0;
    #1;
    total++; if ({busy, done, timeout_err, tx_bit, tx_confirm} !== 5'b0) $display("FAIL rmid_async_clear got=%05b exp=00000", {busy, done, timeout_err, tx_bit, tx_confirm}); else passed++;
    step();
    step();
    reset = 1'b1;
    clr_model();
    do_load(10'h155);
    total++; if ({busy, tx_bit} !== 2'b10) $display("FAIL rmid_reload got=%02b exp=10", {busy, tx_bit}); else passed++;
    wait_done("rmid");
    step();
    total++; if (cap !== 10'h155) $display("FAIL rmid_capture got=%h exp=155", cap); else passed++;
    total++; if (n_conf !== 10) $display("FAIL rmid_confirm_count got=%0d exp=10", n_conf); else passed++;
    total++; if (n_done !== 1) $display("FAIL rmid_done_count got=%0d exp=1", n_done); else passed++;
  endtask

  task automatic test_abort();
    int k;
    clr_model();
    do_load(10'h2F0);
    k = 0;
    while (!tx_confirm && k < 500) begin step(); k++; end
    total++; if (tx_confirm !== 1'b1) $display("FAIL abort_wait_confirm got=%0b exp=1", tx_confirm); else passed++;
    abort = 1'b1;
    step();
    abort = 1'b0;
    total++; if ({tx_confirm, busy, tx_bit} !== 3'b000) $display("FAIL abort_outputs got=%03b exp=000", {tx_confirm, busy, tx_bit}); else passed++;
    repeat (30) step();
    total++; if (n_done !== 0) $display("FAIL abort_no_done got=%0d exp=0", n_done); else passed++;
    total++; if (n_conf !== 1) $display("FAIL abort_no_resume got=%0d exp=1", n_conf); else passed++;
    clr_model();
    abort     = 1'b1;
    load      = 1'b1;
    load_word = 10'h3FF;
    step();
    abort = 1'b0;
    load  = 1'b0;
    total++; if (busy !== 1'b0) $display("FAIL abort_beats_load got=%0b exp=0", busy); else passed++;
    repeat (20) step();
    total++; if (n_conf !== 0) $display("FAIL abort_load_dropped got=%0d exp=0", n_conf); else passed++;
  endtask

  task automatic test_invariants();
    total++; if (viol !== 0) $display("FAIL handshake_invariants got=%0d exp=0", viol); else passed++;
  endtask

  initial begin
    reset     = 1'b0;
    load      = 1'b0;
    load_word = '0;
    abort     = 1'b0;
    test_reset();
    test_word();
    test_ignore_load();
    test_timeout();
    test_reset_mid();
    test_abort();
    test_invariants();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
